// File: rtl/apb_master_pkg.sv
// Shared types and default sizes for the APB master bridge.
package apb_master_pkg;

  localparam int DEF_ADDRESSWIDTH   = 4;
  localparam int DEF_DATAWIDTH      = 8;
  localparam int DEF_FIFO_DEPTH     = 2;
  localparam int DEF_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  typedef struct packed {
    logic                        write;
    logic [DEF_ADDRESSWIDTH-1:0] addr;
    logic [DEF_DATAWIDTH-1:0]    wdata;
  } cmd_t;

  // Width of one packed command entry {write, addr, wdata}.
  function automatic int cmd_width(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command stream, response beat and APB bus of the master bridge.
interface apb_master_bridge_if
  import apb_master_pkg::*;
#(
  parameter int ADDRESSWIDTH = DEF_ADDRESSWIDTH,
  parameter int DATAWIDTH    = DEF_DATAWIDTH
);

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [ADDRESSWIDTH-1:0] cmd_addr;
  logic [DATAWIDTH-1:0]    cmd_wdata;

  logic                    rsp_valid;
  logic                    rsp_write;
  logic [DATAWIDTH-1:0]    rsp_rdata;
  logic                    rsp_timeout;
  logic                    busy;

  logic [ADDRESSWIDTH-1:0] PADDR;
  logic [DATAWIDTH-1:0]    PWDATA;
  logic                    PWRITE;
  logic                    PSELx;
  logic                    PENABLE;
  logic [DATAWIDTH-1:0]    PRDATA;
  logic                    PREADY;

  // Bridge side: accepts commands, emits responses, drives the APB bus.
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_timeout, busy,
    output PADDR, PWDATA, PWRITE, PSELx, PENABLE
  );

  // Environment side: sequencer plus APB slave.
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_timeout, busy,
    input  PADDR, PWDATA, PWRITE, PSELx, PENABLE
  );

endinterface

// File: rtl/apb_cmd_fifo.sv
// Small synchronous FIFO queuing APB commands ahead of the bus FSM.
module apb_cmd_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 13
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Storage needs no reset: the pointers decide which entries are visible.
  always_ff @(posedge PCLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 initiator: drains queued commands onto the bus, one response per transfer.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int ADDRESSWIDTH   = DEF_ADDRESSWIDTH,
  parameter int DATAWIDTH      = DEF_DATAWIDTH,
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic                 PCLK,
  input logic                 PRESETn,
  apb_master_bridge_if.master bus
);

  localparam int CW = cmd_width(ADDRESSWIDTH, DATAWIDTH);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t                  state_q, state_d;
  logic [ADDRESSWIDTH-1:0] paddr_q, paddr_d;
  logic [DATAWIDTH-1:0]    pwdata_q, pwdata_d;
  logic                    pwrite_q, pwrite_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic [TW-1:0]           tcnt_q, tcnt_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_write_q, rsp_write_d;
  logic [DATAWIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_timeout_q, rsp_timeout_d;

  logic [CW-1:0]           fifo_wdata;
  logic [CW-1:0]           fifo_rdata;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic                    head_write;
  logic [ADDRESSWIDTH-1:0] head_addr;
  logic [DATAWIDTH-1:0]    head_wdata;

  assign push       = bus.cmd_valid & ~full;
  assign fifo_wdata = {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
  assign head_write = fifo_rdata[CW-1];
  assign head_addr  = fifo_rdata[DATAWIDTH +: ADDRESSWIDTH];
  assign head_wdata = fifo_rdata[DATAWIDTH-1:0];

  apb_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CW)
  ) u_fifo (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .push    (push),
    .wdata   (fifo_wdata),
    .pop     (pop),
    .rdata   (fifo_rdata),
    .full    (full),
    .empty   (empty)
  );

  // Next-state and next-output logic; a pop always loads the head into the bus registers.
  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pwrite_d      = pwrite_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    tcnt_d        = tcnt_q;
    rsp_valid_d   = 1'b0;
    rsp_write_d   = 1'b0;
    rsp_rdata_d   = '0;
    rsp_timeout_d = 1'b0;
    pop           = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          paddr_d   = head_addr;
          pwdata_d  = head_wdata;
          pwrite_d  = head_write;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        tcnt_d    = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (bus.PREADY) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = pwrite_q;
          rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
          penable_d   = 1'b0;
          if (!empty) begin
            pop      = 1'b1;
            paddr_d  = head_addr;
            pwdata_d = head_wdata;
            pwrite_d = head_write;
            state_d  = SETUP;
          end else begin
            psel_d  = 1'b0;
            state_d = IDLE;
          end
        end else if (TIMEOUT_CYCLES != 0 && tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_write_d   = pwrite_q;
          rsp_timeout_d = 1'b1;
          state_d       = IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State, bus and response registers; reset drops the bus immediately.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      tcnt_q        <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pwrite_q      <= pwrite_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      tcnt_q        <= tcnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_write_q   <= rsp_write_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.cmd_ready   = ~full;
  assign bus.busy        = ~empty | (state_q != IDLE);
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PSELx       = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_write   = rsp_write_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge with a behavioural APB slave.
module tb_apb_master_bridge;

  localparam int TIMEOUT = 16;

  logic PCLK = 1'b0;
  logic PRESETn;

  always #5 PCLK = ~PCLK;

  apb_master_bridge_if #(.ADDRESSWIDTH(4), .DATAWIDTH(8)) bus ();

  apb_master_bridge #(
    .ADDRESSWIDTH   (4),
    .DATAWIDTH      (8),
    .FIFO_DEPTH     (2),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  typedef struct {
    bit         write;
    logic [3:0] addr;
    logic [7:0] wdata;
    int         waits;
  } txn_t;

  typedef struct {
    bit         write;
    logic [7:0] rdata;
    bit         timeout;
  } rsp_t;

  txn_t       bus_q[$];
  rsp_t       rsp_q[$];
  logic [7:0] model_mem [16];
  logic [7:0] slave_mem [16];
  logic [7:0] mem_snapshot [16];
  int         checks = 0;
  int         passes = 0;
  bit         in_access = 0;
  int         waited = 0;
  txn_t       cur;
  rsp_t       exp_rsp;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
  endtask

  // Offers one command, waits for acceptance, then records what the bus and response should show.
  task automatic apply_stimulus(input bit write, input logic [3:0] addr, input logic [7:0] wdata, input int waits);
    bit   taken = 0;
    txn_t t;
    rsp_t r;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = write;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    for (int n = 0; n < 200 && !taken; n++) begin
      @(negedge PCLK);
      taken = bus.cmd_ready;
      @(posedge PCLK);
    end
    if (!taken) begin
      check_output("cmd_accept", 32'(taken), 1);
    end else begin
      t = '{write, addr, wdata, waits};
      bus_q.push_back(t);
      r.write   = write;
      r.timeout = (waits >= TIMEOUT);
      r.rdata   = (write || r.timeout) ? 8'h00 : model_mem[addr];
      if (write && !r.timeout) model_mem[addr] = wdata;
      rsp_q.push_back(r);
    end
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int n = 0; n < 2000 && !done; n++) begin
      @(negedge PCLK);
      done = !bus.busy && rsp_q.size() == 0 && !in_access;
    end
    if (!done) check_output("drain_timeout", rsp_q.size(), 0);
    @(posedge PCLK);
    #1;
  endtask

  task automatic measure_penable(output int len);
    bit seen = 0;
    bit stop = 0;
    len = 0;
    for (int n = 0; n < 60 && !stop; n++) begin
      @(negedge PCLK);
      if (bus.PENABLE) begin
        seen = 1;
        len++;
      end else if (seen) begin
        stop = 1;
      end
    end
  endtask

  // APB slave: checks each transfer against issue order and inserts the planned wait states.
  always @(negedge PCLK) begin
    if (!PRESETn) begin
      in_access   = 0;
      bus.PREADY  = 1'b0;
      bus.PRDATA  = 8'h00;
    end else if (bus.PSELx && bus.PENABLE) begin
      if (!in_access) begin
        in_access = 1;
        waited    = 0;
        if (bus_q.size() == 0) begin
          check_output("bus_q_depth", bus_q.size(), 1);
          cur = '{1'b0, 4'h0, 8'h00, 0};
        end else begin
          cur = bus_q.pop_front();
          check_output("bus_paddr", bus.PADDR, cur.addr);
          check_output("bus_pwrite", bus.PWRITE, cur.write);
          if (cur.write) check_output("bus_pwdata", bus.PWDATA, cur.wdata);
        end
      end
      if (waited >= cur.waits) begin
        bus.PREADY = 1'b1;
        bus.PRDATA = slave_mem[bus.PADDR];
        if (bus.PWRITE) slave_mem[bus.PADDR] = bus.PWDATA;
        in_access = 0;
      end else begin
        bus.PREADY = 1'b0;
        bus.PRDATA = 8'($urandom);
        waited++;
      end
    end else begin
      if (in_access) begin
        check_output("abort_len", waited, TIMEOUT);
        check_output("abort_expected", 32'(cur.waits >= TIMEOUT), 1);
        in_access = 0;
      end
      bus.PREADY = 1'($urandom_range(0, 1));
      bus.PRDATA = 8'($urandom);
    end
  end

  // Response monitor: every beat must match the oldest outstanding expectation.
  always @(negedge PCLK) begin
    if (PRESETn && bus.rsp_valid) begin
      if (rsp_q.size() == 0) begin
        check_output("rsp_q_depth", rsp_q.size(), 1);
      end else begin
        exp_rsp = rsp_q.pop_front();
        check_output("rsp_write", bus.rsp_write, exp_rsp.write);
        check_output("rsp_rdata", bus.rsp_rdata, exp_rsp.rdata);
        check_output("rsp_timeout", bus.rsp_timeout, exp_rsp.timeout);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         len;
    bit [5:0]   pen_pat;
    bit [5:0]   sel_pat;
    bit         full_seen;
    bit         found;
    bit         sel_any;
    int         r;
    int         w;

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 4'h0;
    bus.cmd_wdata = 8'h00;
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = 8'($urandom);
      slave_mem[i] = model_mem[i];
    end

    PRESETn = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    check_output("reset_apb", {bus.PSELx, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA}, 0);
    check_output("reset_rsp", {bus.rsp_valid, bus.rsp_write, bus.rsp_timeout, bus.rsp_rdata}, 0);
    check_output("reset_busy", bus.busy, 0);
    check_output("reset_cmd_ready", bus.cmd_ready, 1);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(posedge PCLK);
    #1;

    $display("[TB] single write latency");
    apply_stimulus(1'b1, 4'd2, 8'hF4, 0);
    @(negedge PCLK);
    check_output("lat_n0_psel", {bus.PSELx, bus.PENABLE}, 2'b00);
    @(negedge PCLK);
    check_output("lat_n1_setup", {bus.PSELx, bus.PENABLE}, 2'b10);
    @(negedge PCLK);
    check_output("lat_n2_access", {bus.PSELx, bus.PENABLE}, 2'b11);
    check_output("lat_n2_fields", {bus.PWRITE, bus.PADDR, bus.PWDATA}, {1'b1, 4'd2, 8'hF4});
    @(negedge PCLK);
    check_output("lat_n3_rsp", {bus.rsp_valid, bus.PSELx, bus.PENABLE}, 3'b100);
    wait_idle();

    $display("[TB] back-to-back burst");
    pen_pat   = '0;
    sel_pat   = '0;
    full_seen = 0;
    fork
      begin
        apply_stimulus(1'b1, 4'd6, 8'h01, 0);
        apply_stimulus(1'b1, 4'd6, 8'h02, 0);
        apply_stimulus(1'b1, 4'd6, 8'h03, 0);
      end
      begin
        found = 0;
        for (int n = 0; n < 20 && !found; n++) begin
          @(negedge PCLK);
          found = bus.PSELx;
        end
        for (int i = 5; i >= 0; i--) begin
          if (i != 5) @(negedge PCLK);
          pen_pat[i] = bus.PENABLE;
          sel_pat[i] = bus.PSELx;
          if (!bus.cmd_ready) full_seen = 1;
        end
      end
    join
    check_output("burst_penable", pen_pat, 6'b010101);
    check_output("burst_psel", sel_pat, 6'b111111);
    check_output("burst_full_seen", full_seen, 1);
    wait_idle();
    check_output("burst_ready_back", bus.cmd_ready, 1);

    $display("[TB] read with wait states");
    model_mem[4] = 8'h5A;
    slave_mem[4] = 8'h5A;
    fork
      apply_stimulus(1'b0, 4'd4, 8'h00, 3);
      measure_penable(len);
    join
    check_output("read_penable_len", len, 4);
    wait_idle();

    $display("[TB] timeout then queued command");
    fork
      begin
        apply_stimulus(1'b0, 4'd3, 8'h00, 40);
        apply_stimulus(1'b1, 4'd5, 8'hC3, 0);
      end
      measure_penable(len);
    join
    check_output("timeout_penable_len", len, TIMEOUT);
    wait_idle();
    apply_stimulus(1'b0, 4'd7, 8'h00, TIMEOUT - 1);
    apply_stimulus(1'b0, 4'd8, 8'h00, TIMEOUT);
    wait_idle();

    $display("[TB] reset during access");
    mem_snapshot = model_mem;
    apply_stimulus(1'b0, 4'd9, 8'h00, 40);
    apply_stimulus(1'b1, 4'd10, 8'h77, 0);
    repeat (4) @(posedge PCLK);
    #1 PRESETn = 1'b0;
    #1;
    check_output("midreset_bus", {bus.PSELx, bus.PENABLE}, 2'b00);
    check_output("midreset_busy", bus.busy, 0);
    check_output("midreset_cmd_ready", bus.cmd_ready, 1);
    check_output("midreset_rsp", bus.rsp_valid, 0);
    bus_q.delete();
    rsp_q.delete();
    in_access = 0;
    model_mem = mem_snapshot;
    @(negedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    sel_any = 0;
    repeat (6) begin
      @(negedge PCLK);
      if (bus.PSELx || bus.busy) sel_any = 1;
    end
    check_output("post_reset_idle", sel_any, 0);
    @(posedge PCLK);
    #1;

    $display("[TB] pointer wrap ordering");
    apply_stimulus(1'b1, 4'd1, 8'h0A, 0);
    apply_stimulus(1'b1, 4'd2, 8'h0B, 0);
    apply_stimulus(1'b1, 4'd3, 8'h0C, 0);
    apply_stimulus(1'b1, 4'd4, 8'h0D, 0);
    for (int a = 1; a <= 4; a++) apply_stimulus(1'b0, 4'(a), 8'h00, 1);
    wait_idle();

    $display("[TB] random traffic");
    for (int k = 0; k < 60; k++) begin
      r = int'($urandom_range(0, 9));
      w = (r < 7) ? r % 4 : (r == 7) ? TIMEOUT - 1 : (r == 8) ? 40 : 0;
      apply_stimulus(1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom), w);
      repeat ($urandom_range(0, 2)) @(posedge PCLK);
      #1;
    end
    wait_idle();
    check_output("final_rsp_q_empty", rsp_q.size(), 0);
    check_output("final_bus_q_empty", bus_q.size(), 0);
    check_output("final_busy", bus.busy, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
